instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction-fetch (IF) stage of the MIPS pipeline, acting as the initiator on the instruction-memory read port. It owns the program counter, drives the word-aligned fetch address, and captures the returned instruction into the IF/ID pipeline register. It handles pipeline stalls, flushes and control-flow redirects from the ID stage (jump) and the EX stage (branch).

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word-aligned.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous, active-high reset.
- Stall  in  1  hazard unit: hold PC and IF/ID.
- Flush  in  1  force a bubble into IF/ID on the next edge.
- BranchTaken  in  1  EX-stage branch resolved taken.
- BranchTarget  in  32  branch destination byte address.
- JumpTaken  in  1  ID-stage jump (j/jal/jr).
- JumpTarget  in  32  jump destination byte address.
- ImemAddress  out  32  byte address to instruction memory; equals PC.
- ImemInstruction  in  32  instruction word returned combinationally by instruction memory.
- PC  out  32  current PC (debug/display).
- IF_ID_Instruction  out  32  registered instruction.
- IF_ID_PCPlus4  out  32  registered PC+4 of that instruction.
- IF_ID_Valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble.
- MisalignErr  out  1  one-cycle pulse: a redirect target had nonzero bits [1:0].

## Operation
- Instruction memory is combinational and byte-addressed, indexed by ImemAddress[8:2]. Bits [1:0] of ImemAddress are always 00.
- Next-PC selection, highest priority first:
  - BranchTaken → BranchTarget & ~3.
  - JumpTaken → JumpTarget & ~3.
  - Stall → PC (hold).
  - Otherwise → PC + 4, 32-bit wrap (32'hFFFF_FFFC → 0).
- A redirect overrides Stall on the PC only. The redirect is always taken in the cycle it is asserted.
- IF/ID update, highest priority first:
  - BranchTaken, JumpTaken or Flush → Instruction = 32'h0 (NOP), PCPlus4 = 0, Valid = 0.
  - Stall → hold all three fields.
  - Otherwise → Instruction = ImemInstruction, PCPlus4 = PC + 4, Valid = 1.
- MisalignErr is registered. It is 1 for exactly the cycle after a redirect that was taken (by priority) with target[1:0] ≠ 00. It is 0 otherwise.
- Reset values: PC = RESET_PC; IF_ID_Instruction = 0; IF_ID_PCPlus4 = 0; IF_ID_Valid = 0; MisalignErr = 0.
- Reset asserted mid-operation clears every register immediately, without waiting for a clock edge. The first fetch after deassertion is at RESET_PC.

## Timing
- Zero-cycle address path: ImemAddress is a combinational copy of the PC register.
- One-cycle latency: the instruction at PC appears on IF_ID_Instruction after the next rising edge.
- Steady-state throughput is one instruction per cycle.
- Redirect penalty:
  - Jump: 1 bubble (the wrong-path fetch is discarded).
  - Branch: the instruction in IF is discarded here. Squashing the ID-stage instruction is the hazard unit's job, done via its own control.
- BranchTaken and JumpTaken in the same cycle: the branch wins (it is the older instruction), and the jump is dropped.
- Stall and Flush in the same cycle: Flush wins for IF/ID, and the PC holds.
- Holding Stall for N cycles keeps PC and IF/ID bit-identical for N cycles.

## Structure
- Shared package/header mips_defs holds the constants NOP_INSTR = 32'h0 and DEFAULT_RESET_PC = 32'h0, plus the word-alignment mask.
- One sub-module, pc_register: 32-bit register with async reset to RESET_PC and a load enable. instruction_fetch instantiates it alongside the next-PC mux and the IF/ID register.
- The IF/ID register stays inline in instruction_fetch. It is not a separate module.

## Test plan
- Reset then free-run 7 cycles against the standard program image → IF_ID_Instruction sequence 0x00008820, 0x22320002, …; IF_ID_PCPlus4 = 4, 8, 12, …; IF_ID_Valid rises on the first edge after reset release.
- Stall held for 3 cycles at PC = 8 → PC stays 8, IF/ID keeps 0x22320002/PCPlus4 = 8, then fetch resumes at 8.
- JumpTaken with JumpTarget = 0x14 at PC = 4 → next PC = 0x14, one bubble (Valid = 0), then instruction word 5 with PCPlus4 = 0x18.
- BranchTaken (target 0x0) and JumpTaken (target 0x18) in the same cycle, with Stall = 1 → PC = 0x0, bubble inserted.
- JumpTarget = 0x1E → PC = 0x1C, MisalignErr high for exactly one cycle.
- Rst pulsed asynchronously between edges at PC = 0x10 → PC = 0, IF_ID_Valid = 0 without a clock edge; fetch restarts at 0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS pipeline constants: NOP encoding, default reset PC and word alignment.
package mips_defs;
   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [XLEN-1:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & WORD_ALIGN_MASK;
   endfunction
endpackage

// File: rtl/instruction_fetch_pc_register.sv
// Program counter: 32-bit register with async reset to RESET_PC and a load enable.
module pc_register
   import mips_defs::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [XLEN-1:0] d,
   output logic [XLEN-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= RESET_PC;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: owns the PC, drives the instruction-memory address and fills IF/ID,
// honouring stalls, flushes, ID-stage jumps and EX-stage branches.
module instruction_fetch
   import mips_defs::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            Clk,
   input  logic            Rst,
   input  logic            Stall,
   input  logic            Flush,
   input  logic            BranchTaken,
   input  logic [XLEN-1:0] BranchTarget,
   input  logic            JumpTaken,
   input  logic [XLEN-1:0] JumpTarget,
   output logic [XLEN-1:0] ImemAddress,
   input  logic [XLEN-1:0] ImemInstruction,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] IF_ID_Instruction,
   output logic [XLEN-1:0] IF_ID_PCPlus4,
   output logic            IF_ID_Valid,
   output logic            MisalignErr
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] next_pc;
   logic            pc_load;
   logic            redirect;
   logic            misalign_next;

   assign pc_plus4    = pc_q + XLEN'(4);
   assign redirect    = BranchTaken | JumpTaken;
   assign ImemAddress = pc_q;
   assign PC          = pc_q;

   // Next-PC select: the older branch beats the jump, and any redirect beats a stall.
   always_comb begin
      next_pc       = pc_plus4;
      pc_load       = 1'b1;
      misalign_next = 1'b0;
      if (BranchTaken) begin
         next_pc       = align_word(BranchTarget);
         misalign_next = |BranchTarget[1:0];
      end else if (JumpTaken) begin
         next_pc       = align_word(JumpTarget);
         misalign_next = |JumpTarget[1:0];
      end else if (Stall) begin
         next_pc = pc_q;
         pc_load = 1'b0;
      end
   end

   pc_register #(
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clk (Clk),
      .rst (Rst),
      .en  (pc_load),
      .d   (next_pc),
      .q   (pc_q)
   );

   // IF/ID pipeline register: a redirect or flush squashes the wrong-path fetch.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         IF_ID_Instruction <= NOP_INSTR;
         IF_ID_PCPlus4     <= '0;
         IF_ID_Valid       <= 1'b0;
      end else if (redirect || Flush) begin
         IF_ID_Instruction <= NOP_INSTR;
         IF_ID_PCPlus4     <= '0;
         IF_ID_Valid       <= 1'b0;
      end else if (!Stall) begin
         IF_ID_Instruction <= ImemInstruction;
         IF_ID_PCPlus4     <= pc_plus4;
         IF_ID_Valid       <= 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         MisalignErr <= 1'b0;
      else
         MisalignErr <= misalign_next;
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch against a small program image.
module tb_instruction_fetch;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp_taken;
   logic [31:0] jmp_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic [31:0] pc;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pcp4;
   logic        ifid_valid;
   logic        misalign;

   logic [31:0] rom [0:127];
   int          vecs;
   int          errs;

   instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .Clk               (clk),
      .Rst               (rst),
      .Stall             (stall),
      .Flush             (flush),
      .BranchTaken       (br_taken),
      .BranchTarget      (br_target),
      .JumpTaken         (jmp_taken),
      .JumpTarget        (jmp_target),
      .ImemAddress       (imem_addr),
      .ImemInstruction   (imem_instr),
      .PC                (pc),
      .IF_ID_Instruction (ifid_instr),
      .IF_ID_PCPlus4     (ifid_pcp4),
      .IF_ID_Valid       (ifid_valid),
      .MisalignErr       (misalign)
   );

   assign imem_instr = rom[imem_addr[8:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of control inputs, then sample 1 time unit after the edge.
   task automatic cycle(input logic s, input logic f, input logic b, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt);
      stall = s; flush = f; br_taken = b; br_target = bt; jmp_taken = j; jmp_target = jt;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      stall = 1'b0; flush = 1'b0; br_taken = 1'b0; jmp_taken = 1'b0;
      br_target = 32'h0; jmp_target = 32'h0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      vecs++;
      if ({ifid_instr, ifid_pcp4, ifid_valid, pc, misalign, imem_addr} !== {32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0}) begin
         errs++;
         $display("FAIL reset_state: got instr=%h p4=%h v=%b pc=%h mis=%b addr=%h expected all zero",
                  ifid_instr, ifid_pcp4, ifid_valid, pc, misalign, imem_addr);
      end
      @(posedge clk); #1;
      vecs++;
      if ({ifid_valid, pc} !== {1'b0, 32'h0}) begin
         errs++;
         $display("FAIL reset_held: got v=%b pc=%h expected v=0 pc=0", ifid_valid, pc);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_free_run();
      for (int k = 1; k <= 7; k++) begin
         idle();
         vecs++;
         if ({ifid_instr, ifid_pcp4, ifid_valid, pc, misalign} !== {rom[k-1], 32'(4*k), 1'b1, 32'(4*k), 1'b0}) begin
            errs++;
            $display("FAIL free_run[%0d]: got instr=%h p4=%h v=%b pc=%h mis=%b expected instr=%h p4=%h v=1 pc=%h mis=0",
                     k, ifid_instr, ifid_pcp4, ifid_valid, pc, misalign, rom[k-1], 32'(4*k), 32'(4*k));
         end
      end
   endtask

   task automatic test_stall();
      do_reset();
      idle(); idle();
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         vecs++;
         if ({ifid_instr, ifid_pcp4, ifid_valid, pc, imem_addr} !== {32'h22320002, 32'h8, 1'b1, 32'h8, 32'h8}) begin
            errs++;
            $display("FAIL stall_hold[%0d]: got instr=%h p4=%h v=%b pc=%h addr=%h expected 22320002/8/1/8/8",
                     k, ifid_instr, ifid_pcp4, ifid_valid, pc, imem_addr);
         end
      end
      idle();
      vecs++;
      if ({ifid_instr, ifid_pcp4, ifid_valid, pc} !== {rom[2], 32'hC, 1'b1, 32'hC}) begin
         errs++;
         $display("FAIL stall_resume: got instr=%h p4=%h v=%b pc=%h expected %h/c/1/c",
                  ifid_instr, ifid_pcp4, ifid_valid, pc, rom[2]);
      end
   endtask

   task automatic test_jump();
      do_reset();
      idle();
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h14);
      vecs++;
      if ({ifid_instr, ifid_pcp4, ifid_valid, pc, misalign} !== {32'h0, 32'h0, 1'b0, 32'h14, 1'b0}) begin
         errs++;
         $display("FAIL jump_bubble: got instr=%h p4=%h v=%b pc=%h mis=%b expected 0/0/0/14/0",
                  ifid_instr, ifid_pcp4, ifid_valid, pc, misalign);
      end
      idle();
      vecs++;
      if ({ifid_instr, ifid_pcp4, ifid_valid, pc} !== {rom[5], 32'h18, 1'b1, 32'h18}) begin
         errs++;
         $display("FAIL jump_target: got instr=%h p4=%h v=%b pc=%h expected %h/18/1/18",
                  ifid_instr, ifid_pcp4, ifid_valid, pc, rom[5]);
      end
   endtask

   task automatic test_branch_priority();
      // PC is 0x18 here; branch to 0 beats jump to 0x18 and the stall
      cycle(1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 32'h18);
      vecs++;
      if ({ifid_instr, ifid_pcp4, ifid_valid, pc, misalign} !== {32'h0, 32'h0, 1'b0, 32'h0, 1'b0}) begin
         errs++;
         $display("FAIL branch_wins: got instr=%h p4=%h v=%b pc=%h mis=%b expected 0/0/0/0/0",
                  ifid_instr, ifid_pcp4, ifid_valid, pc, misalign);
      end
      idle();
      vecs++;
      if ({ifid_instr, ifid_pcp4, ifid_valid, pc} !== {rom[0], 32'h4, 1'b1, 32'h4}) begin
         errs++;
         $display("FAIL branch_refetch: got instr=%h p4=%h v=%b pc=%h expected %h/4/1/4",
                  ifid_instr, ifid_pcp4, ifid_valid, pc, rom[0]);
      end
      // Aligned branch with a misaligned jump: jump is dropped, no error
      cycle(1'b0, 1'b0, 1'b1, 32'h8, 1'b1, 32'h1E);
      vecs++;
      if ({pc, misalign, ifid_valid} !== {32'h8, 1'b0, 1'b0}) begin
         errs++;
         $display("FAIL branch_drops_jump: got pc=%h mis=%b v=%b expected pc=8 mis=0 v=0", pc, misalign, ifid_valid);
      end
   endtask

   task automatic test_misalign();
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1E);
      vecs++;
      if ({pc, misalign, ifid_valid} !== {32'h1C, 1'b1, 1'b0}) begin
         errs++;
         $display("FAIL misalign_pulse: got pc=%h mis=%b v=%b expected pc=1c mis=1 v=0", pc, misalign, ifid_valid);
      end
      idle();
      vecs++;
      if ({ifid_instr, ifid_pcp4, ifid_valid, pc, misalign} !== {rom[7], 32'h20, 1'b1, 32'h20, 1'b0}) begin
         errs++;
         $display("FAIL misalign_clear: got instr=%h p4=%h v=%b pc=%h mis=%b expected %h/20/1/20/0",
                  ifid_instr, ifid_pcp4, ifid_valid, pc, misalign, rom[7]);
      end
      cycle(1'b0, 1'b0, 1'b1, 32'h13, 1'b0, 32'h0);
      vecs++;
      if ({pc, misalign} !== {32'h10, 1'b1}) begin
         errs++;
         $display("FAIL branch_misalign: got pc=%h mis=%b expected pc=10 mis=1", pc, misalign);
      end
   endtask

   task automatic test_flush_stall();
      // PC is 0x10 here
      cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      vecs++;
      if ({ifid_instr, ifid_pcp4, ifid_valid, pc, misalign} !== {32'h0, 32'h0, 1'b0, 32'h10, 1'b0}) begin
         errs++;
         $display("FAIL flush_stall: got instr=%h p4=%h v=%b pc=%h mis=%b expected 0/0/0/10/0",
                  ifid_instr, ifid_pcp4, ifid_valid, pc, misalign);
      end
      cycle(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      vecs++;
      if ({ifid_valid, ifid_instr, pc} !== {1'b0, 32'h0, 32'h14}) begin
         errs++;
         $display("FAIL flush_only: got v=%b instr=%h pc=%h expected v=0 instr=0 pc=14", ifid_valid, ifid_instr, pc);
      end
   endtask

   task automatic test_wrap();
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
      vecs++;
      if ({pc, imem_addr} !== {32'hFFFF_FFFC, 32'hFFFF_FFFC}) begin
         errs++;
         $display("FAIL wrap_jump: got pc=%h addr=%h expected fffffffc", pc, imem_addr);
      end
      idle();
      vecs++;
      if ({ifid_instr, ifid_pcp4, ifid_valid, pc} !== {rom[127], 32'h0, 1'b1, 32'h0}) begin
         errs++;
         $display("FAIL wrap_around: got instr=%h p4=%h v=%b pc=%h expected %h/0/1/0",
                  ifid_instr, ifid_pcp4, ifid_valid, pc, rom[127]);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int k = 0; k < 4; k++) idle();
      vecs++;
      if (pc !== 32'h10) begin
         errs++;
         $display("FAIL async_setup: got pc=%h expected 10", pc);
      end
      #2 rst = 1'b1;
      #1;
      vecs++;
      if ({pc, imem_addr, ifid_valid, ifid_instr, ifid_pcp4} !== {32'h0, 32'h0, 1'b0, 32'h0, 32'h0}) begin
         errs++;
         $display("FAIL async_reset: got pc=%h addr=%h v=%b instr=%h p4=%h expected all zero",
                  pc, imem_addr, ifid_valid, ifid_instr, ifid_pcp4);
      end
      #2 rst = 1'b0;
      idle();
      vecs++;
      if ({ifid_instr, ifid_pcp4, ifid_valid, pc} !== {rom[0], 32'h4, 1'b1, 32'h4}) begin
         errs++;
         $display("FAIL async_restart: got instr=%h p4=%h v=%b pc=%h expected %h/4/1/4",
                  ifid_instr, ifid_pcp4, ifid_valid, pc, rom[0]);
      end
   endtask

   initial begin
      vecs = 0;
      errs = 0;
      for (int i = 0; i < 128; i++) rom[i] = 32'hA000_0000 + 32'(i);
      rom[0] = 32'h0000_8820;
      rom[1] = 32'h2232_0002;
      rst = 1'b1;
      stall = 1'b0; flush = 1'b0; br_taken = 1'b0; jmp_taken = 1'b0;
      br_target = 32'h0; jmp_target = 32'h0;

      test_reset();
      test_free_run();
      test_stall();
      test_jump();
      test_branch_priority();
      test_misalign();
      test_flush_stall();
      test_wrap();
      test_async_reset();

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
